// File: rtl/gate_test_sequencer.sv
// ============================================================================
//  Module   : gate_test_sequencer
//  Purpose  : Sweeps a single-output gate through every input vector, checks
//             each result against EXPECTED and reports per-vector failures.
//             Optional: GATE_SEQ_AUTO_REPEAT_EN restarts the sweep after DONE.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module gate_test_sequencer #(
    parameter int                        N_INPUTS      = 1,
    parameter logic [(1<<N_INPUTS)-1:0]  EXPECTED      = 2'b01,
    parameter int                        SETTLE_CYCLES = 2,
    parameter int                        DWELL_CYCLES  = 25_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      dut_out,
    output logic [N_INPUTS-1:0]       dut_in,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [(1<<N_INPUTS)-1:0]  fail_mask
);

    localparam int c_CNT_MAX = (DWELL_CYCLES > SETTLE_CYCLES) ? DWELL_CYCLES : SETTLE_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0]  c_SETTLE_LAST = c_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]  c_DWELL_LAST  = c_CNT_W'(DWELL_CYCLES - 1);
    localparam logic [N_INPUTS-1:0] c_IDX_LAST    = '1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_DWELL  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t                     r_state;
    logic                       r_start_q;
    logic [c_CNT_W-1:0]         r_cnt;
    logic [N_INPUTS-1:0]        r_idx;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_pass;
    logic [(1<<N_INPUTS)-1:0]   r_fail_mask;
    logic                       w_start_edge;

    assign w_start_edge = start & ~r_start_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_start_q   <= 1'b0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_mask <= '0;
        end else begin
            r_start_q <= start;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_edge) begin
                        r_state     <= ST_SETTLE;
                        r_idx       <= '0;
                        r_cnt       <= '0;
                        r_fail_mask <= '0;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == c_SETTLE_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    r_fail_mask[r_idx] <= (dut_out != EXPECTED[r_idx]);
                    r_state            <= ST_DWELL;
                end
                ST_DWELL: begin
                    if (r_cnt == c_DWELL_LAST) begin
                        r_cnt <= '0;
                        if (r_idx == c_IDX_LAST) begin
                            // The last vector's sample already landed in r_fail_mask
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (r_fail_mask == '0);
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= ST_SETTLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
`ifdef GATE_SEQ_AUTO_REPEAT_EN
                    // pass is kept so it stays readable until the next sweep ends
                    r_state     <= ST_SETTLE;
                    r_idx       <= '0;
                    r_cnt       <= '0;
                    r_fail_mask <= '0;
                    r_done      <= 1'b0;
                    r_busy      <= 1'b1;
`else
                    if (w_start_edge) begin
                        r_state     <= ST_SETTLE;
                        r_idx       <= '0;
                        r_cnt       <= '0;
                        r_fail_mask <= '0;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_busy      <= 1'b1;
                    end
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dut_in    = r_idx;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_mask = r_fail_mask;

endmodule

`default_nettype wire

// File: tb/tb_gate_test_sequencer.sv
// ============================================================================
//  Module   : tb_gate_test_sequencer
//  Purpose  : Checks gate_test_sequencer against a timeline-based model of a
//             sweep, plus hand-derived expectations for 1- and 2-input gates.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gate_test_sequencer;

    localparam int          S   = 2;
    localparam int          D   = 3;
    localparam int          P   = S + 1 + D;
    localparam int          NV  = 4;
    localparam logic [3:0]  EXP = 4'b1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  dut_in;
    logic        dut_out;
    logic        busy, done, pass;
    logic [3:0]  fail_mask;

    logic [0:0]  dut_in2;
    logic        dut_out2;
    logic        busy2, done2, pass2;
    logic [1:0]  fail_mask2;

    int          mode;
    logic        noise;
    logic        mode2;

    int          n_cmp  = 0;
    int          n_fail = 0;

    // model of the 2-input sweep, keyed on clocks elapsed since the start edge
    bit          m_run;
    int          m_k;
    logic [3:0]  m_fm;
    logic        m_done, m_pass, m_busy;
    logic [1:0]  m_vec;
    logic        m_prev;
    logic        s_start, s_out;

    always #5 clk = ~clk;

    assign dut_out  = (mode == 0) ? (&dut_in) : (mode == 1) ? (|dut_in) : noise;
    assign dut_out2 = mode2 ? ~dut_in2[0] : 1'b0;

    gate_test_sequencer #(
        .N_INPUTS(2), .EXPECTED(EXP), .SETTLE_CYCLES(S), .DWELL_CYCLES(D)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .dut_out(dut_out),
        .dut_in(dut_in), .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask)
    );

    gate_test_sequencer #(
        .N_INPUTS(1), .SETTLE_CYCLES(S), .DWELL_CYCLES(D)
    ) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .dut_out(dut_out2),
        .dut_in(dut_in2), .busy(busy2), .done(done2), .pass(pass2), .fail_mask(fail_mask2)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_k    = 0;
        m_fm   = '0;
        m_done = 1'b0;
        m_pass = 1'b0;
        m_busy = 1'b0;
        m_vec  = '0;
        m_prev = 1'b0;
    endtask

    task automatic model_step();
        logic edge_seen;
        int   v;
        edge_seen = s_start & ~m_prev;
        m_prev    = s_start;
        if (m_run) begin
            v = m_k / P;
            if ((m_k % P) == S) m_fm[v] = (s_out != EXP[v]);
            m_k++;
            if (m_k == NV * P) begin
                m_run  = 1'b0;
                m_done = 1'b1;
                m_busy = 1'b0;
                m_pass = (m_fm == 4'b0000);
            end else begin
                m_vec = 2'(m_k / P);
            end
        end else if (edge_seen) begin
            m_run  = 1'b1;
            m_k    = 0;
            m_fm   = '0;
            m_done = 1'b0;
            m_pass = 1'b0;
            m_busy = 1'b1;
            m_vec  = '0;
        end
    endtask

    task automatic compare_all();
        chk("dut_in",    8'(dut_in),    8'(m_vec));
        chk("busy",      8'(busy),      8'(m_busy));
        chk("done",      8'(done),      8'(m_done));
        chk("pass",      8'(pass),      8'(m_pass));
        chk("fail_mask", 8'(fail_mask), 8'(m_fm));
    endtask

    task automatic tick();
        @(negedge clk);
        s_start = start;
        s_out   = dut_out;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 0;
        mode2 = 1'b1;
        noise = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dut_in", 8'(dut_in), 8'h00);
        chk("rst_busy",   8'(busy),   8'h00);
        chk("rst_done",   8'(done),   8'h00);
        chk("rst_pass",   8'(pass),   8'h00);
        chk("rst_mask",   8'(fail_mask), 8'h00);
        chk("rst_mask2",  8'(fail_mask2), 8'h00);
        rst = 1'b0;

        // AND gate and NOT gate, both expected to pass
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 5)  chk("not_vec_before", 8'(dut_in2), 8'h00);
            if (i == 6)  chk("not_vec_after",  8'(dut_in2), 8'h01);
            if (i == 6)  chk("and_vec1",       8'(dut_in),  8'h01);
            if (i == 18) chk("and_vec3",       8'(dut_in),  8'h03);
            if (i == 11) chk("not_done_early", 8'(done2),   8'h00);
            if (i == 12) begin
                chk("not_done",  8'(done2),      8'h01);
                chk("not_pass",  8'(pass2),      8'h01);
                chk("not_mask",  8'(fail_mask2), 8'h00);
                chk("not_busy",  8'(busy2),      8'h00);
            end
            if (i == 23) chk("and_done_early", 8'(done), 8'h00);
            if (i == 24) begin
                chk("and_done", 8'(done), 8'h01);
                chk("and_pass", 8'(pass), 8'h01);
            end
        end

        // OR gate against the AND table; stuck-at-0 against the NOT table
        mode  = 1;
        mode2 = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 12) begin
                chk("stuck_mask", 8'(fail_mask2), 8'h01);
                chk("stuck_pass", 8'(pass2),      8'h00);
                chk("stuck_done", 8'(done2),      8'h01);
            end
            if (i == 24) begin
                chk("or_mask", 8'(fail_mask), 8'h06);
                chk("or_pass", 8'(pass),      8'h00);
            end
        end

        // start held high: a single sweep, DONE held afterwards
        mode  = 0;
        mode2 = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        chk("held_done", 8'(done), 8'h01);
        start = 1'b0;
        repeat (5) tick();

        // second start edge mid-sweep must not disturb timing
        for (int i = 0; i <= 28; i++) begin
            start = (i == 0) || (i == 4);
            tick();
            if (i == 23) chk("restart_done_early", 8'(done), 8'h00);
            if (i == 24) chk("restart_done",       8'(done), 8'h01);
        end
        start = 1'b0;

        // asynchronous reset while vector 1 dwells
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        chk("pre_rst_vec", 8'(dut_in), 8'h01);
        rst = 1'b1;
        #1;
        chk("arst_dut_in", 8'(dut_in),    8'h00);
        chk("arst_busy",   8'(busy),      8'h00);
        chk("arst_done",   8'(done),      8'h00);
        chk("arst_mask",   8'(fail_mask), 8'h00);
        model_reset();
        #1;
        rst   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 24; i++) tick();
        chk("post_rst_done", 8'(done), 8'h01);
        chk("post_rst_pass", 8'(pass), 8'h01);

        // randomized starts, gate behaviour and occasional resets
        for (int i = 0; i < 1500; i++) begin
            start = ($urandom_range(0, 15) == 0);
            noise = 1'($urandom);
            mode2 = 1'($urandom);
            if ($urandom_range(0, 99) == 0) mode = int'($urandom_range(0, 2));
            if ($urandom_range(0, 299) == 0) reset_pulse();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
